// File: rtl/nibram_port_arbiter_pkg.sv
// Shared encodings and default widths for the nibble-RAM port-A arbiter.
// Used by nibram_port_arbiter and nibram_fill.
package nibram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_t;

endpackage

// File: rtl/nibram_fill.sv
// Fill engine: walks every RAM address once, writing a latched constant nibble.
// Only instantiated when NIBRAM_FILL_EN is defined.
module nibram_fill
  import nibram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              done
);

  logic              busy_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [DATA_W-1:0] value_r;
  logic              done_s;

  // The last write of a fill is the one to the all-ones address.
  assign done_s = busy_r && (cnt_r == {ADDR_W{1'b1}});

  // Counter, latched value and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r  <= 1'b0;
      cnt_r   <= {ADDR_W{1'b0}};
      value_r <= {DATA_W{1'b0}};
    end else if (start && !busy_r) begin
      busy_r  <= 1'b1;
      cnt_r   <= {ADDR_W{1'b0}};
      value_r <= value;
    end else if (busy_r) begin
      busy_r  <= !done_s;
      cnt_r   <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      value_r <= value_r;
    end else begin
      busy_r  <= busy_r;
      cnt_r   <= cnt_r;
      value_r <= value_r;
    end
  end

  assign busy = busy_r;
  assign addr = cnt_r;
  assign data = value_r;
  assign done = done_s;

endmodule

// File: rtl/nibram_port_arbiter.sv
// Round-robin arbiter sharing port A of a 4096x4 block RAM between two requesters.
// Optional fill engine enabled by defining NIBRAM_FILL_EN.
module nibram_port_arbiter
  import nibram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wren,
  input  logic [DATA_W-1:0] m0_wrdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rddata,
  output logic              m0_rdvalid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wren,
  input  logic [DATA_W-1:0] m1_wrdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rddata,
  output logic              m1_rdvalid,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  state_t            state_r;
  gnt_t              last_r;
  gnt_t              rd_tag_r;
  logic              m0_rdvalid_r;
  logic              m1_rdvalid_r;
  logic [DATA_W-1:0] m0_hold_r;
  logic [DATA_W-1:0] m1_hold_r;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              fill_go_s;
  logic              fill_busy_s;
  logic              fill_done_s;
  logic [ADDR_W-1:0] fill_addr_s;
  logic [DATA_W-1:0] fill_data_s;

`ifdef NIBRAM_FILL_EN
  assign fill_go_s = fill_start && (state_r == ST_IDLE) && !reset;

  nibram_fill #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fill (
    .clk   (clk),
    .reset (reset),
    .start (fill_go_s),
    .value (fill_value),
    .busy  (fill_busy_s),
    .addr  (fill_addr_s),
    .data  (fill_data_s),
    .done  (fill_done_s)
  );
`else
  logic unused_fill_s;
  assign unused_fill_s = ^{fill_start, fill_value};
  assign fill_go_s     = 1'b0;
  assign fill_busy_s   = 1'b0;
  assign fill_done_s   = 1'b0;
  assign fill_addr_s   = {ADDR_W{1'b0}};
  assign fill_data_s   = {DATA_W{1'b0}};
`endif

  // Grant selection: none during reset, fill, or the cycle a fill is accepted.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset || (state_r != ST_IDLE) || fill_go_s) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (m0_req && m1_req) begin
      if (last_r == GNT_M1) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (m0_req) begin
      gnt0_s = 1'b1;
    end else if (m1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Port A steering: fill engine, then granted requester, else idle.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {ADDR_W{1'b0}};
    ram_di   = {DATA_W{1'b0}};
    if (reset) begin
      ram_en = 1'b0;
    end else if (fill_busy_s) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = fill_addr_s;
      ram_di   = fill_data_s;
    end else if (gnt0_s) begin
      ram_en   = 1'b1;
      ram_we   = m0_wren;
      ram_addr = m0_addr;
      ram_di   = m0_wrdata;
    end else if (gnt1_s) begin
      ram_en   = 1'b1;
      ram_we   = m1_wren;
      ram_addr = m1_addr;
      ram_di   = m1_wrdata;
    end else begin
      ram_en = 1'b0;
    end
  end

  // State machine, last-grant pointer and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_r       <= GNT_M1;
      rd_tag_r     <= GNT_M0;
      m0_rdvalid_r <= 1'b0;
      m1_rdvalid_r <= 1'b0;
      m0_hold_r    <= {DATA_W{1'b0}};
      m1_hold_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: state_r <= fill_go_s ? ST_FILL : ST_IDLE;
        ST_FILL: state_r <= fill_done_s ? ST_IDLE : ST_FILL;
        default: state_r <= ST_IDLE;
      endcase
      if (gnt0_s) begin
        last_r   <= GNT_M0;
        rd_tag_r <= GNT_M0;
      end else if (gnt1_s) begin
        last_r   <= GNT_M1;
        rd_tag_r <= GNT_M1;
      end else begin
        last_r   <= last_r;
        rd_tag_r <= rd_tag_r;
      end
      m0_rdvalid_r <= gnt0_s && !m0_wren;
      m1_rdvalid_r <= gnt1_s && !m1_wren;
      // Hold the returned nibble so rddata stays stable after the pulse.
      m0_hold_r <= (m0_rdvalid_r && (rd_tag_r == GNT_M0)) ? ram_do : m0_hold_r;
      m1_hold_r <= (m1_rdvalid_r && (rd_tag_r == GNT_M1)) ? ram_do : m1_hold_r;
    end
  end

  assign m0_ack     = gnt0_s;
  assign m1_ack     = gnt1_s;
  assign m0_rdvalid = m0_rdvalid_r;
  assign m1_rdvalid = m1_rdvalid_r;
  assign m0_rddata  = (m0_rdvalid_r && (rd_tag_r == GNT_M0)) ? ram_do : m0_hold_r;
  assign m1_rddata  = (m1_rdvalid_r && (rd_tag_r == GNT_M1)) ? ram_do : m1_hold_r;
  assign fill_busy  = fill_busy_s;

endmodule

// File: tb/tb_nibram_port_arbiter.sv
// Directed self-checking bench for nibram_port_arbiter with a behavioural 4096x4 RAM.
// Fill scenarios are compiled only when NIBRAM_FILL_EN is defined.
module tb_nibram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_wren = 1'b0, m1_req = 1'b0, m1_wren = 1'b0;
  logic [11:0] m0_addr = 12'h000, m1_addr = 12'h000;
  logic [3:0]  m0_wrdata = 4'h0, m1_wrdata = 4'h0;
  logic        m0_ack, m0_rdvalid, m1_ack, m1_rdvalid;
  logic [3:0]  m0_rddata, m1_rddata;
  logic        fill_start = 1'b0;
  logic [3:0]  fill_value = 4'h0;
  logic        fill_busy, ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_di;
  logic [3:0]  ram_do = 4'h0;
  logic [3:0]  mem [0:4095];

  int checks = 0;
  int errors = 0;

  nibram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wren(m0_wren), .m0_wrdata(m0_wrdata),
    .m0_ack(m0_ack), .m0_rddata(m0_rddata), .m0_rdvalid(m0_rdvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wren(m1_wren), .m1_wrdata(m1_wrdata),
    .m1_ack(m1_ack), .m1_rddata(m1_rddata), .m1_rdvalid(m1_rdvalid),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int a);
    logic [31:0] t;
    t = a * 7 + 3;
    return t[3:0];
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pat(i);
  end

  // Write-first synchronous RAM model
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_do <= ram_di;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    step;
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    fill_start = 1'b0;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    m0_req = 1'b1;
    m0_addr = 12'h055;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate: ack=%b en=%b we=%b required 0 0 0", m0_ack, ram_en, ram_we);
    end
    step;
    m0_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fill_busy !== 1'b0 || m0_rdvalid !== 1'b0 || m1_rdvalid !== 1'b0 ||
        m0_rddata !== 4'h0 || m1_rddata !== 4'h0 || ram_en !== 1'b0 ||
        ram_addr !== 12'h000 || ram_di !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b v0=%b v1=%b d0=%h d1=%h en=%b addr=%h di=%h required all 0",
               fill_busy, m0_rdvalid, m1_rdvalid, m0_rddata, m1_rddata, ram_en, ram_addr, ram_di);
    end
  endtask

  task automatic test_write_read;
    step;
    m0_req = 1'b1; m0_wren = 1'b1; m0_addr = 12'h123; m0_wrdata = 4'hA;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'h123 || ram_di !== 4'hA) begin
      errors++;
      $display("FAIL wr_ack: ack=%b en=%b we=%b addr=%h di=%h required 1 1 1 123 a",
               m0_ack, ram_en, ram_we, ram_addr, ram_di);
    end
    step;
    m0_wren = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || ram_we !== 1'b0 || m0_rdvalid !== 1'b0 || m1_rdvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack: ack=%b we=%b v0=%b v1=%b required 1 0 0 0", m0_ack, ram_we, m0_rdvalid, m1_rdvalid);
    end
    step;
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rdvalid !== 1'b1 || m0_rddata !== 4'hA || m1_rdvalid !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL rd_return: v0=%b d0=%h v1=%b en=%b required 1 a 0 0", m0_rdvalid, m0_rddata, m1_rdvalid, ram_en);
    end
    step;
    @(negedge clk);
    checks++;
    if (m0_rdvalid !== 1'b0 || m0_rddata !== 4'hA || m1_rdvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: v0=%b d0=%h v1=%b required 0 a 0", m0_rdvalid, m0_rddata, m1_rdvalid);
    end
  endtask

  task automatic test_round_robin;
    logic [11:0] a0, a1, prev_addr;
    logic        exp0, prev0;
    do_reset;
    a0 = 12'h200;
    a1 = 12'h300;
    prev0 = 1'b0;
    prev_addr = 12'h000;
    for (int k = 0; k < 6; k++) begin
      step;
      m0_req = 1'b1; m0_wren = 1'b0; m0_addr = a0;
      m1_req = 1'b1; m1_wren = 1'b0; m1_addr = a1;
      @(negedge clk);
      exp0 = (k % 2 == 0);
      checks++;
      if (m0_ack !== exp0 || m1_ack !== !exp0) begin
        errors++;
        $display("FAIL rr_ack[%0d]: ack0=%b ack1=%b required %b %b", k, m0_ack, m1_ack, exp0, !exp0);
      end
      if (k > 0) begin
        checks++;
        if (m0_rdvalid !== prev0 || m1_rdvalid !== !prev0 ||
            (prev0 ? m0_rddata : m1_rddata) !== pat(int'(prev_addr))) begin
          errors++;
          $display("FAIL rr_data[%0d]: v0=%b v1=%b d0=%h d1=%h required v0=%b data=%h",
                   k, m0_rdvalid, m1_rdvalid, m0_rddata, m1_rddata, prev0, pat(int'(prev_addr)));
        end
      end
      prev0 = exp0;
      prev_addr = exp0 ? a0 : a1;
      if (exp0) a0 = a0 + 12'h001;
      else a1 = a1 + 12'h001;
    end
    step;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rdvalid !== 1'b1 || m1_rddata !== pat(12'h302) || m0_rdvalid !== 1'b0 || m0_rddata !== pat(12'h202)) begin
      errors++;
      $display("FAIL rr_last: v1=%b d1=%h v0=%b d0=%h required 1 %h 0 %h",
               m1_rdvalid, m1_rddata, m0_rdvalid, m0_rddata, pat(12'h302), pat(12'h202));
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      step;
      m1_req = (k < 3);
      m1_wren = 1'b0;
      m1_addr = 12'h400 + 12'(k);
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ack[%0d]: ack1=%b ack0=%b required 1 0", k, m1_ack, m0_ack);
        end
      end
      if (k > 0) begin
        checks++;
        if (m1_rdvalid !== 1'b1 || m1_rddata !== pat(12'h400 + k - 1) || m0_rdvalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data[%0d]: v1=%b d1=%h v0=%b required 1 %h 0",
                   k, m1_rdvalid, m1_rddata, m0_rdvalid, pat(12'h400 + k - 1));
        end
      end
    end
    m1_req = 1'b0;
  endtask

`ifdef NIBRAM_FILL_EN
  task automatic test_fill;
    int  busy_cycles;
    int  bad_cycles;
    logic [3:0] rd_exp [3];
    logic [11:0] rd_addr [3];
    rd_addr[0] = 12'h000; rd_addr[1] = 12'h800; rd_addr[2] = 12'hFFF;
    busy_cycles = 0;
    bad_cycles = 0;
    step;
    fill_start = 1'b1; fill_value = 4'h5;
    m0_req = 1'b1; m0_wren = 1'b0; m0_addr = rd_addr[0];
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_accept: ack0=%b busy=%b required 0 0", m0_ack, fill_busy);
    end
    step;
    fill_start = 1'b0;
    fill_value = 4'h0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (fill_busy !== 1'b1) break;
      busy_cycles++;
      if (m0_ack !== 1'b0 || ram_we !== 1'b1 || ram_di !== 4'h5) bad_cycles++;
      step;
    end
    checks++;
    if (busy_cycles !== 4096 || bad_cycles !== 0) begin
      errors++;
      $display("FAIL fill_len: busy_cycles=%0d bad=%0d required 4096 0", busy_cycles, bad_cycles);
    end
    checks++;
    if (m0_ack !== 1'b1) begin
      errors++;
      $display("FAIL fill_after_ack: ack0=%b required 1", m0_ack);
    end
    for (int k = 1; k < 4; k++) begin
      step;
      m0_req = (k < 3);
      if (k < 3) m0_addr = rd_addr[k];
      @(negedge clk);
      checks++;
      if (m0_rdvalid !== 1'b1 || m0_rddata !== 4'h5) begin
        errors++;
        $display("FAIL fill_read[%0d]: v0=%b d0=%h required 1 5", k - 1, m0_rdvalid, m0_rddata);
      end
    end
    rd_exp[0] = 4'h0;
  endtask

  task automatic test_fill_reset;
    logic [11:0] a [3];
    logic [3:0]  e [3];
    a[0] = 12'h000; a[1] = 12'd99; a[2] = 12'd100;
    e[0] = 4'h9;    e[1] = 4'h9;   e[2] = 4'h5;
    step;
    m0_req = 1'b0;
    fill_start = 1'b1; fill_value = 4'h9;
    step;
    fill_start = 1'b0;
    for (int c = 0; c < 99; c++) step;
    step;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL fillrst_we: we=%b required 0", ram_we);
    end
    step;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL fillrst_busy: busy=%b required 0", fill_busy);
    end
    for (int k = 0; k < 4; k++) begin
      step;
      m1_req = (k < 3);
      m1_wren = 1'b0;
      if (k < 3) m1_addr = a[k];
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (m1_rdvalid !== 1'b1 || m1_rddata !== e[k-1]) begin
          errors++;
          $display("FAIL fillrst_read[%0d]: v1=%b d1=%h required 1 %h", k - 1, m1_rdvalid, m1_rddata, e[k-1]);
        end
      end
    end
  endtask
`else
  task automatic test_no_fill;
    step;
    m0_req = 1'b0; m1_req = 1'b0;
    fill_start = 1'b1; fill_value = 4'h5;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_en !== 1'b0 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL nofill_start: we=%b en=%b busy=%b required 0 0 0", ram_we, ram_en, fill_busy);
    end
    step;
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0 || fill_busy !== 1'b0) begin
        errors++;
        $display("FAIL nofill_idle[%0d]: we=%b busy=%b required 0 0", k, ram_we, fill_busy);
      end
      step;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_round_robin;
    test_back_to_back;
`ifdef NIBRAM_FILL_EN
    test_fill;
    test_fill_reset;
`else
    test_no_fill;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
